pwm_fade_ctrl: RTL and testbench

//  Sequencer that drives the duty input of a pwm_basic instance. On a start

---
 rtl/pwm_fade_ctrl.sv | 171 +++++++++++++++++
 tb/tb_pwm_fade_ctrl.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_fade_ctrl.sv
// -----------------------------------------------------------------------------
// pwm_fade_ctrl
//
// Ramps the duty value of a downstream PWM from its current setting toward a
// target in fixed-size steps. A step is applied only on the edge that samples a
// PWM period_end pulse. Each PWM period therefore runs with a single, stable
// duty value. Typical uses are LED fades and motor soft start/stop.
//
// Parameters
//   R  duty width; must match the R of the driven PWM
//   H  width of the hold counter (periods between steps)
//
// Ports
//   clk         in   1  single clock, rising edge
//   reset_n     in   1  asynchronous active-low reset
//   start       in   1  request a ramp; only looked at while idle
//   target      in   R  final duty value, latched when a ramp is accepted
//   step        in   R  duty change per step, latched; 0 behaves as 1
//   hold        in   H  a step happens every (hold+1) period_end pulses
//   period_end  in   1  one-cycle pulse at the PWM counter wrap
//   abort       in   1  cancel the ramp; duty freezes where it is
//   duty        out  R  registered duty for the PWM
//   busy        out  1  high while a ramp is in progress
//   done        out  1  one-cycle pulse when duty reaches the target
// -----------------------------------------------------------------------------
module pwm_fade_ctrl #(
  parameter int R = 8,
  parameter int H = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic [R-1:0] target,
  input  logic [R-1:0] step,
  input  logic [H-1:0] hold,
  input  logic         period_end,
  input  logic         abort,
  output logic [R-1:0] duty,
  output logic         busy,
  output logic         done
);

  typedef enum logic {
    IDLE = 1'b0,
    RAMP = 1'b1
  } state_t;

  state_t       state, state_n;
  logic [R-1:0] duty_n;
  logic         busy_n;
  logic         done_n;
  logic [R-1:0] target_q, target_n;
  logic [R-1:0] step_q, step_n;
  logic [H-1:0] hold_q, hold_n;
  logic [H-1:0] hold_cnt, hold_cnt_n;

  // Candidate duty value for the next step.
  logic [R:0]   sum_ext;
  logic [R:0]   diff_ext;
  logic [R:0]   target_ext;
  logic [R-1:0] stepped;

  // The next step is computed with one spare bit. An upward step that passes
  // the target is clamped to it, so it cannot wrap through 2^R. A downward
  // step that would go below zero sets the spare bit, and that case is also
  // clamped to the target. No direction register is kept: the comparison of
  // duty with target_q decides the direction fresh on every step.
  always_comb begin
    sum_ext    = {1'b0, duty} + {1'b0, step_q};
    diff_ext   = {1'b0, duty} - {1'b0, step_q};
    target_ext = {1'b0, target_q};
    stepped    = target_q;
    if (duty < target_q) begin
      if (sum_ext < target_ext) begin
        stepped = sum_ext[R-1:0];
      end
    end else if (duty > target_q) begin
      if (!diff_ext[R] && (diff_ext > target_ext)) begin
        stepped = diff_ext[R-1:0];
      end
    end
  end

  // Next-state and output logic. done is a one-cycle pulse, so it defaults to
  // 0 every cycle. abort takes priority over start and period_end in both
  // states. It leaves duty where it is and produces no done pulse.
  always_comb begin
    state_n    = state;
    duty_n     = duty;
    busy_n     = busy;
    done_n     = 1'b0;
    target_n   = target_q;
    step_n     = step_q;
    hold_n     = hold_q;
    hold_cnt_n = hold_cnt;

    if (abort) begin
      state_n    = IDLE;
      busy_n     = 1'b0;
      hold_cnt_n = '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            if (target != duty) begin
              target_n   = target;
              step_n     = (step == '0) ? R'(1) : step;
              hold_n     = hold;
              hold_cnt_n = '0;
              busy_n     = 1'b1;
              state_n    = RAMP;
            end else begin
              // A ramp to the current value finishes at once. It gives the
              // done pulse without ever raising busy.
              done_n = 1'b1;
            end
          end
        end

        RAMP: begin
          // While a ramp runs, start is ignored so the latched ramp settings
          // stay intact.
          if (period_end) begin
            if (hold_cnt != hold_q) begin
              hold_cnt_n = hold_cnt + H'(1);
            end else begin
              hold_cnt_n = '0;
              duty_n     = stepped;
              if (stepped == target_q) begin
                busy_n  = 1'b0;
                done_n  = 1'b1;
                state_n = IDLE;
              end
            end
          end
        end

        default: begin
          state_n = IDLE;
          busy_n  = 1'b0;
        end
      endcase
    end
  end

  // All state and outputs are registered. The new duty therefore appears one
  // cycle after the period_end that triggered the step, which is the first
  // cycle of the new PWM period.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      duty     <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      target_q <= '0;
      step_q   <= '0;
      hold_q   <= '0;
      hold_cnt <= '0;
    end else begin
      state    <= state_n;
      duty     <= duty_n;
      busy     <= busy_n;
      done     <= done_n;
      target_q <= target_n;
      step_q   <= step_n;
      hold_q   <= hold_n;
      hold_cnt <= hold_cnt_n;
    end
  end

endmodule

// File: tb/tb_pwm_fade_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pwm_fade_ctrl
//
// Self-checking bench for pwm_fade_ctrl. The reference model works at the
// level of a whole ramp. When a ramp is accepted, the model precomputes the
// full list of duty values the ramp will pass through. It then pops one value
// every (hold+1) period_end pulses.
// -----------------------------------------------------------------------------
module tb_pwm_fade_ctrl;

  localparam int R = 8;
  localparam int H = 8;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         start = 1'b0;
  logic [R-1:0] target = '0;
  logic [R-1:0] step = '0;
  logic [H-1:0] hold = '0;
  logic         period_end = 1'b0;
  logic         abort = 1'b0;
  logic [R-1:0] duty;
  logic         busy;
  logic         done;

  int checks = 0;
  int passed = 0;

  // Reference model state
  int m_duty;
  bit m_busy;
  bit m_done;
  int m_plan[$];
  int m_hold;
  int m_pe_count;

  pwm_fade_ctrl #(.R(R), .H(H)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .target     (target),
    .step       (step),
    .hold       (hold),
    .period_end (period_end),
    .abort      (abort),
    .duty       (duty),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("[TB] FAIL watchdog: simulation time limit expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic model_reset();
    m_duty = 0;
    m_busy = 0;
    m_done = 0;
    m_plan.delete();
    m_hold = 0;
    m_pe_count = 0;
  endtask

  // Model of one clock edge. On an accepted start, the whole sequence of
  // clamped steps toward the target is built up front.
  task automatic model_step(input bit s, input int tg, input int st, input int hd,
                            input bit pe, input bit ab);
    int v;
    int sz;
    m_done = 0;
    if (ab) begin
      m_busy = 0;
      m_plan.delete();
    end else if (!m_busy) begin
      if (s) begin
        if (tg == m_duty) begin
          m_done = 1;
        end else begin
          sz = (st == 0) ? 1 : st;
          v = m_duty;
          m_plan.delete();
          while (v != tg) begin
            if (v < tg) v = (v + sz > tg) ? tg : v + sz;
            else        v = (v - sz < tg) ? tg : v - sz;
            m_plan.push_back(v);
          end
          m_hold = hd;
          m_pe_count = 0;
          m_busy = 1;
        end
      end
    end else if (pe) begin
      m_pe_count++;
      if (m_pe_count == m_hold + 1) begin
        m_pe_count = 0;
        m_duty = m_plan.pop_front();
        if (m_plan.size() == 0) begin
          m_busy = 0;
          m_done = 1;
        end
      end
    end
  endtask

  // Drives one cycle of inputs at the falling edge, advances the model, and
  // returns 1 time unit after the rising edge so outputs can be sampled.
  task automatic cycle(input bit s, input int tg, input int st, input int hd,
                       input bit pe, input bit ab);
    @(negedge clk);
    start      = s;
    target     = tg[R-1:0];
    step       = st[R-1:0];
    hold       = hd[H-1:0];
    period_end = pe;
    abort      = ab;
    model_step(s, tg, st, hd, pe, ab);
    @(posedge clk);
    #1;
  endtask

  // Setup helper: runs a complete ramp with continuous period_end pulses.
  task automatic ramp_to(input int tg, input int st, input int hd);
    int n;
    n = 0;
    cycle(1, tg, st, hd, 0, 0);
    while (m_busy && n < 1000) begin
      cycle(0, 0, 0, 0, 1, 0);
      n++;
    end
    if (n >= 1000) begin
      checks++;
      $display("[TB] FAIL ramp_to_timeout: model still busy=%0d required 0", m_busy);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++; if (duty !== 8'd0) $display("[TB] FAIL reset_duty: got %0d want 0", duty); else passed++;
    checks++; if (busy !== 1'b0) $display("[TB] FAIL reset_busy: got %0b want 0", busy); else passed++;
    checks++; if (done !== 1'b0) $display("[TB] FAIL reset_done: got %0b want 0", done); else passed++;
    @(negedge clk);
    reset_n = 1'b1;
    cycle(0, 0, 0, 0, 0, 0);
    checks++; if (duty !== 8'd0) $display("[TB] FAIL release_duty: got %0d want 0", duty); else passed++;
    checks++; if (busy !== 1'b0 || done !== 1'b0)
      $display("[TB] FAIL release_flags: busy=%0b done=%0b want 0/0", busy, done); else passed++;
  endtask

  task automatic test_ramp_up();
    int exp_duty[4] = '{3, 6, 9, 10};
    cycle(1, 10, 3, 0, 0, 0);
    checks++; if (busy !== 1'b1 || duty !== 8'd0)
      $display("[TB] FAIL up_start: busy=%0b duty=%0d want 1/0", busy, duty); else passed++;
    for (int i = 0; i < 4; i++) begin
      cycle(0, 0, 0, 0, 1, 0);
      checks++; if (duty !== 8'(exp_duty[i]))
        $display("[TB] FAIL up_duty[%0d]: got %0d want %0d", i, duty, exp_duty[i]); else passed++;
      checks++; if (done !== (i == 3) || busy !== (i < 3))
        $display("[TB] FAIL up_flags[%0d]: done=%0b busy=%0b want %0b/%0b", i, done, busy, i == 3, i < 3);
      else passed++;
    end
    cycle(0, 0, 0, 0, 0, 0);
    checks++; if (done !== 1'b0 || busy !== 1'b0)
      $display("[TB] FAIL up_after: done=%0b busy=%0b want 0/0", done, busy); else passed++;
  endtask

  task automatic test_ramp_down_hold();
    int exp_duty[4] = '{200, 100, 100, 0};
    ramp_to(200, 255, 0);
    checks++; if (duty !== 8'd200) $display("[TB] FAIL down_setup: got %0d want 200", duty); else passed++;
    cycle(1, 0, 100, 1, 0, 0);
    for (int i = 0; i < 4; i++) begin
      cycle(0, 0, 0, 0, 1, 0);
      checks++; if (duty !== 8'(exp_duty[i]) || done !== (i == 3))
        $display("[TB] FAIL down_pe[%0d]: duty=%0d done=%0b want %0d/%0b", i, duty, done, exp_duty[i], i == 3);
      else passed++;
      if (i < 3) begin
        cycle(0, 0, 0, 0, 0, 0);
        checks++; if (duty !== 8'(exp_duty[i]) || busy !== 1'b1)
          $display("[TB] FAIL down_idle[%0d]: duty=%0d busy=%0b want %0d/1", i, duty, busy, exp_duty[i]);
        else passed++;
      end
    end
  endtask

  task automatic test_saturation();
    ramp_to(250, 255, 0);
    cycle(1, 255, 10, 0, 0, 0);
    cycle(0, 0, 0, 0, 1, 0);
    checks++; if (duty !== 8'd255 || done !== 1'b1 || busy !== 1'b0)
      $display("[TB] FAIL sat_up: duty=%0d done=%0b busy=%0b want 255/1/0", duty, done, busy); else passed++;
    cycle(1, 253, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 1, 0);
    checks++; if (duty !== 8'd254 || done !== 1'b0)
      $display("[TB] FAIL step0_first: duty=%0d done=%0b want 254/0", duty, done); else passed++;
    cycle(0, 0, 0, 0, 1, 0);
    checks++; if (duty !== 8'd253 || done !== 1'b1)
      $display("[TB] FAIL step0_second: duty=%0d done=%0b want 253/1", duty, done); else passed++;
    ramp_to(5, 255, 0);
    cycle(1, 0, 200, 0, 0, 0);
    cycle(0, 0, 0, 0, 1, 0);
    checks++; if (duty !== 8'd0 || done !== 1'b1)
      $display("[TB] FAIL sat_down: duty=%0d done=%0b want 0/1", duty, done); else passed++;
  endtask

  task automatic test_abort();
    ramp_to(0, 255, 0);
    cycle(1, 100, 10, 0, 0, 0);
    repeat (3) cycle(0, 0, 0, 0, 1, 0);
    checks++; if (duty !== 8'd30) $display("[TB] FAIL abort_pre: got %0d want 30", duty); else passed++;
    cycle(0, 0, 0, 0, 1, 1);
    checks++; if (duty !== 8'd30 || busy !== 1'b0 || done !== 1'b0)
      $display("[TB] FAIL abort_edge: duty=%0d busy=%0b done=%0b want 30/0/0", duty, busy, done); else passed++;
    cycle(0, 0, 0, 0, 1, 0);
    checks++; if (duty !== 8'd30 || done !== 1'b0)
      $display("[TB] FAIL abort_after: duty=%0d done=%0b want 30/0", duty, done); else passed++;
    cycle(1, 99, 1, 0, 0, 1);
    checks++; if (busy !== 1'b0 || done !== 1'b0)
      $display("[TB] FAIL abort_vs_start: busy=%0b done=%0b want 0/0", busy, done); else passed++;
    cycle(1, 50, 10, 0, 0, 0);
    cycle(0, 0, 0, 0, 1, 0);
    checks++; if (duty !== 8'd40) $display("[TB] FAIL resume_first: got %0d want 40", duty); else passed++;
    cycle(0, 0, 0, 0, 1, 0);
    checks++; if (duty !== 8'd50 || done !== 1'b1)
      $display("[TB] FAIL resume_done: duty=%0d done=%0b want 50/1", duty, done); else passed++;
  endtask

  task automatic test_back_to_back();
    ramp_to(30, 255, 0);
    cycle(1, 30, 5, 0, 0, 0);
    checks++; if (done !== 1'b1 || busy !== 1'b0)
      $display("[TB] FAIL equal_start: done=%0b busy=%0b want 1/0", done, busy); else passed++;
    cycle(0, 0, 0, 0, 0, 0);
    checks++; if (done !== 1'b0 || busy !== 1'b0 || duty !== 8'd30)
      $display("[TB] FAIL equal_after: done=%0b busy=%0b duty=%0d want 0/0/30", done, busy, duty); else passed++;
    cycle(1, 60, 10, 0, 0, 0);
    cycle(0, 0, 0, 0, 1, 0);
    cycle(1, 0, 1, 0, 0, 0);
    checks++; if (busy !== 1'b1 || duty !== 8'd40)
      $display("[TB] FAIL restart_ignored: busy=%0b duty=%0d want 1/40", busy, duty); else passed++;
    cycle(1, 0, 1, 0, 1, 0);
    checks++; if (duty !== 8'd50) $display("[TB] FAIL restart_step: got %0d want 50", duty); else passed++;
    cycle(0, 0, 0, 0, 1, 0);
    checks++; if (duty !== 8'd60 || done !== 1'b1 || busy !== 1'b0)
      $display("[TB] FAIL restart_done: duty=%0d done=%0b busy=%0b want 60/1/0", duty, done, busy); else passed++;
  endtask

  task automatic test_async_reset();
    cycle(1, 100, 10, 0, 0, 0);
    cycle(0, 0, 0, 0, 1, 0);
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    checks++; if (duty !== 8'd0 || busy !== 1'b0 || done !== 1'b0)
      $display("[TB] FAIL async_reset: duty=%0d busy=%0b done=%0b want 0/0/0", duty, busy, done); else passed++;
    model_reset();
    @(negedge clk);
    start = 0; period_end = 0; abort = 0;
    reset_n = 1'b1;
  endtask

  task automatic test_random();
    bit s, pe, ab;
    int tg, st, hd;
    for (int i = 0; i < 500; i++) begin
      s  = ($urandom_range(0, 5) == 0);
      tg = ($urandom_range(0, 9) == 0) ? m_duty : int'($urandom_range(0, 255));
      st = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 40));
      hd = $urandom_range(0, 3);
      pe = ($urandom_range(0, 2) == 0);
      ab = ($urandom_range(0, 39) == 0);
      cycle(s, tg, st, hd, pe, ab);
      checks++; if (duty !== 8'(m_duty))
        $display("[TB] FAIL rand_duty[%0d]: got %0d want %0d", i, duty, m_duty); else passed++;
      checks++; if (busy !== m_busy)
        $display("[TB] FAIL rand_busy[%0d]: got %0b want %0b", i, busy, m_busy); else passed++;
      checks++; if (done !== m_done)
        $display("[TB] FAIL rand_done[%0d]: got %0b want %0b", i, done, m_done); else passed++;
    end
  endtask

  initial begin
    $display("[TB] pwm_fade_ctrl bench starting");
    test_reset();
    test_ramp_up();
    test_ramp_down_hold();
    test_saturation();
    test_abort();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
